// File: rtl/unified_mem_arbiter_if.sv
// Bundle of datapath-side and memory-side signals around the unified memory arbiter.
// The master modport is the arbiter's view; slave is the view of the datapath/memory environment.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] if_adr;
    logic [DATA_W-1:0] if_inst;
    logic [ADDR_W-1:0] dm_adr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_read;
    logic              dm_write;
    logic [DATA_W-1:0] dm_rdata;
    logic              pipe_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              timeout_err;
    logic [31:0]       stall_cnt;

    modport master (
        input  if_adr, dm_adr, dm_wdata, dm_read, dm_write, mem_rdata, mem_ack,
        output if_inst, dm_rdata, pipe_stall, mem_req, mem_we, mem_adr, mem_wdata,
               timeout_err, stall_cnt
    );

    modport slave (
        output if_adr, dm_adr, dm_wdata, dm_read, dm_write, mem_rdata, mem_ack,
        input  if_inst, dm_rdata, pipe_stall, mem_req, mem_we, mem_adr, mem_wdata,
               timeout_err, stall_cnt
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and MEM-stage data access,
// freezing the pipeline until the data transaction (if any) and the fetch have both completed.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.master bus
);
    localparam bit WDOG_EN = (TIMEOUT > 0);
    localparam int WCW     = $clog2(TIMEOUT + 2);
    localparam logic [WCW-1:0] WAIT_LAST = WDOG_EN ? WCW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        DECIDE,
        DATA_WAIT,
        FETCH_WAIT,
        RELEASE
    } state_e;

    state_e            state_q,      state_d;
    logic              memReq_q,     memReq_d;
    logic              memWe_q,      memWe_d;
    logic [ADDR_W-1:0] memAdr_q,     memAdr_d;
    logic [DATA_W-1:0] memWdata_q,   memWdata_d;
    logic [DATA_W-1:0] ifInst_q,     ifInst_d;
    logic [DATA_W-1:0] dmRdata_q,    dmRdata_d;
    logic              pipeStall_q,  pipeStall_d;
    logic              timeoutErr_q, timeoutErr_d;
    logic [31:0]       stallCnt_q,   stallCnt_d;
    logic [WCW-1:0]    waitCnt_q,    waitCnt_d;

    logic ackValid;
    logic timeoutHit;

    always_comb begin
        state_d      = state_q;
        memReq_d     = memReq_q;
        memWe_d      = memWe_q;
        memAdr_d     = memAdr_q;
        memWdata_d   = memWdata_q;
        ifInst_d     = ifInst_q;
        dmRdata_d    = dmRdata_q;
        pipeStall_d  = pipeStall_q;
        timeoutErr_d = timeoutErr_q;
        waitCnt_d    = waitCnt_q;
        stallCnt_d   = stallCnt_q + 32'(pipeStall_q);

        // An ack only counts while a request is outstanding; the watchdog fires on the last allowed silent cycle.
        ackValid   = bus.mem_ack && memReq_q;
        timeoutHit = WDOG_EN && !ackValid && (waitCnt_q == WAIT_LAST);

        case (state_q)
            DECIDE: begin
                waitCnt_d   = '0;
                memReq_d    = 1'b1;
                pipeStall_d = 1'b1;
                if (bus.dm_read || bus.dm_write) begin
                    state_d    = DATA_WAIT;
                    memAdr_d   = bus.dm_adr;
                    memWe_d    = bus.dm_write;
                    memWdata_d = bus.dm_wdata;
                end else begin
                    state_d  = FETCH_WAIT;
                    memAdr_d = bus.if_adr;
                    memWe_d  = 1'b0;
                end
            end

            DATA_WAIT: begin
                if (ackValid || timeoutHit) begin
                    state_d   = FETCH_WAIT;
                    waitCnt_d = '0;
                    memReq_d  = 1'b1;
                    memAdr_d  = bus.if_adr;
                    memWe_d   = 1'b0;
                    if (!memWe_q) begin
                        dmRdata_d = ackValid ? bus.mem_rdata : '0;
                    end
                    if (timeoutHit) begin
                        timeoutErr_d = 1'b1;
                    end
                end else if (WDOG_EN) begin
                    waitCnt_d = waitCnt_q + WCW'(1);
                end
            end

            FETCH_WAIT: begin
                if (ackValid || timeoutHit) begin
                    state_d     = RELEASE;
                    waitCnt_d   = '0;
                    memReq_d    = 1'b0;
                    memWe_d     = 1'b0;
                    pipeStall_d = 1'b0;
                    ifInst_d    = ackValid ? bus.mem_rdata : '0;
                    if (timeoutHit) begin
                        timeoutErr_d = 1'b1;
                    end
                end else if (WDOG_EN) begin
                    waitCnt_d = waitCnt_q + WCW'(1);
                end
            end

            RELEASE: begin
                state_d     = DECIDE;
                pipeStall_d = 1'b1;
            end

            default: begin
                state_d = DECIDE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= DECIDE;
            memReq_q     <= 1'b0;
            memWe_q      <= 1'b0;
            memAdr_q     <= '0;
            memWdata_q   <= '0;
            ifInst_q     <= '0;
            dmRdata_q    <= '0;
            pipeStall_q  <= 1'b1;
            timeoutErr_q <= 1'b0;
            stallCnt_q   <= '0;
            waitCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            memReq_q     <= memReq_d;
            memWe_q      <= memWe_d;
            memAdr_q     <= memAdr_d;
            memWdata_q   <= memWdata_d;
            ifInst_q     <= ifInst_d;
            dmRdata_q    <= dmRdata_d;
            pipeStall_q  <= pipeStall_d;
            timeoutErr_q <= timeoutErr_d;
            stallCnt_q   <= stallCnt_d;
            waitCnt_q    <= waitCnt_d;
        end
    end

    assign bus.if_inst     = ifInst_q;
    assign bus.dm_rdata    = dmRdata_q;
    assign bus.pipe_stall  = pipeStall_q;
    assign bus.mem_req     = memReq_q;
    assign bus.mem_we      = memWe_q;
    assign bus.mem_adr     = memAdr_q;
    assign bus.mem_wdata   = memWdata_q;
    assign bus.timeout_err = timeoutErr_q;
    assign bus.stall_cnt   = stallCnt_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: a behavioural memory answers requests with per-transaction
// latency while queued expectations (transactions and pipeline releases) are checked as they occur.
module tb_unified_mem_arbiter;
    localparam int TO     = 4;
    localparam int BUDGET = 40;
    localparam int NVEC   = 8;

    logic clk = 1'b0;
    logic rst;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdata;
        int          lat;
    } txn_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rdata;
        int          stalls;
        logic        err;
    } rel_t;

    typedef struct {
        logic [31:0] ifAdr;
        logic [31:0] dmAdr;
        logic [31:0] dmWdata;
        logic        dmRead;
        logic        dmWrite;
        int          dLat;
        int          fLat;
        logic [31:0] expInst;
        logic [31:0] expRdata;
        int          expStall;
        logic        expErr;
    } vec_t;

    txn_t        expTxnQ[$];
    rel_t        expRelQ[$];
    logic [31:0] memArr[logic [31:0]];
    vec_t        vecs[NVEC];
    int          checks    = 0;
    int          passes    = 0;
    int          reqCycles = 0;
    int          curStalls = 0;
    int          totStall  = 0;

    function automatic logic [31:0] memRead(input logic [31:0] adr);
        return memArr.exists(adr) ? memArr[adr] : 32'h0;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: acks the front expected transaction after its latency; lat<0 never acks.
    task automatic memRespond();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        if (bus.mem_req === 1'b1) begin
            if (expTxnQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_req: got request at 0x%08h, expected no request", bus.mem_adr);
            end else begin
                txn_t t;
                t = expTxnQ[0];
                checkVal("req_adr", bus.mem_adr, t.adr);
                checkVal("req_we", 32'(bus.mem_we), 32'(t.we));
                if (t.we) begin
                    checkVal("req_wdata", bus.mem_wdata, t.wdata);
                end
                if (t.lat >= 0 && reqCycles >= t.lat) begin
                    bus.mem_ack = 1'b1;
                    if (t.we) begin
                        memArr[bus.mem_adr] = bus.mem_wdata;
                    end else begin
                        bus.mem_rdata = memRead(bus.mem_adr);
                    end
                    reqCycles = 0;
                    void'(expTxnQ.pop_front());
                end else begin
                    reqCycles++;
                end
            end
        end else if (reqCycles > 0) begin
            if (expTxnQ.size() > 0 && expTxnQ[0].lat < 0) begin
                checkVal("timeout_wait_cycles", 32'(reqCycles), 32'(TO));
                void'(expTxnQ.pop_front());
            end else begin
                checkVal("req_dropped_early", 32'(reqCycles), 32'h0);
            end
            reqCycles = 0;
        end
    endtask

    task automatic tick();
        memRespond();
        if (bus.pipe_stall === 1'b1) begin
            curStalls++;
            totStall++;
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        rel_t r;
        if (expRelQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL %s_release: got a release, expected none", tag);
        end else begin
            r = expRelQ.pop_front();
            checkVal({tag, "_if_inst"}, bus.if_inst, r.inst);
            checkVal({tag, "_dm_rdata"}, bus.dm_rdata, r.rdata);
            checkVal({tag, "_stall_cycles"}, 32'(curStalls), 32'(r.stalls));
            checkVal({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'(r.err));
            checkVal({tag, "_stall_cnt"}, bus.stall_cnt, 32'(totStall));
        end
        curStalls = 0;
    endtask

    task automatic runUntilRelease(input string tag);
        for (int c = 0; c < BUDGET; c++) begin
            if (bus.pipe_stall === 1'b0) begin
                checkOutput(tag);
                return;
            end
            tick();
        end
        checks++;
        $display("[TB] FAIL %s_release: pipe_stall still 1 after %0d cycles, expected a release", tag, BUDGET);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.if_adr   = v.ifAdr;
        bus.dm_adr   = v.dmAdr;
        bus.dm_wdata = v.dmWdata;
        bus.dm_read  = v.dmRead;
        bus.dm_write = v.dmWrite;
        if (v.dmRead || v.dmWrite) begin
            expTxnQ.push_back('{adr: v.dmAdr, we: v.dmWrite, wdata: v.dmWdata, lat: v.dLat});
        end
        expTxnQ.push_back('{adr: v.ifAdr, we: 1'b0, wdata: 32'h0, lat: v.fLat});
        expRelQ.push_back('{inst: v.expInst, rdata: v.expRdata, stalls: v.expStall, err: v.expErr});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vec_t bootVec;

        rst           = 1'b0;
        bus.if_adr    = 32'h0;
        bus.dm_adr    = 32'h0;
        bus.dm_wdata  = 32'h0;
        bus.dm_read   = 1'b0;
        bus.dm_write  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        memArr[32'h00] = 32'h8C01_0004;
        memArr[32'h04] = 32'h0022_1820;
        memArr[32'h08] = 32'hAC03_0020;
        memArr[32'h0C] = 32'h3C1F_00FF;
        memArr[32'h10] = 32'hDEAD_BEEF;
        memArr[32'h14] = 32'h0BAD_F00D;
        memArr[32'h30] = 32'hCAFE_0001;

        vecs[0] = '{ifAdr: 32'h04, dmAdr: 32'h10, dmWdata: 32'h0, dmRead: 1'b1, dmWrite: 1'b0, dLat: 2, fLat: 1,
                    expInst: 32'h0022_1820, expRdata: 32'hDEAD_BEEF, expStall: 6, expErr: 1'b0};
        vecs[1] = '{ifAdr: 32'h08, dmAdr: 32'h20, dmWdata: 32'h1234_5678, dmRead: 1'b0, dmWrite: 1'b1, dLat: 0, fLat: 0,
                    expInst: 32'hAC03_0020, expRdata: 32'hDEAD_BEEF, expStall: 3, expErr: 1'b0};
        vecs[2] = '{ifAdr: 32'h0C, dmAdr: 32'h20, dmWdata: 32'h0, dmRead: 1'b1, dmWrite: 1'b0, dLat: 0, fLat: 0,
                    expInst: 32'h3C1F_00FF, expRdata: 32'h1234_5678, expStall: 3, expErr: 1'b0};
        vecs[3] = '{ifAdr: 32'h30, dmAdr: 32'h14, dmWdata: 32'h55AA_55AA, dmRead: 1'b1, dmWrite: 1'b1, dLat: 1, fLat: 0,
                    expInst: 32'hCAFE_0001, expRdata: 32'h1234_5678, expStall: 4, expErr: 1'b0};
        vecs[4] = '{ifAdr: 32'h00, dmAdr: 32'h14, dmWdata: 32'h0, dmRead: 1'b1, dmWrite: 1'b0, dLat: 0, fLat: 2,
                    expInst: 32'h8C01_0004, expRdata: 32'h55AA_55AA, expStall: 5, expErr: 1'b0};
        vecs[5] = '{ifAdr: 32'h04, dmAdr: 32'h0, dmWdata: 32'h0, dmRead: 1'b0, dmWrite: 1'b0, dLat: 0, fLat: -1,
                    expInst: 32'h0, expRdata: 32'h55AA_55AA, expStall: 5, expErr: 1'b1};
        vecs[6] = '{ifAdr: 32'h08, dmAdr: 32'h0, dmWdata: 32'h0, dmRead: 1'b0, dmWrite: 1'b0, dLat: 0, fLat: 3,
                    expInst: 32'hAC03_0020, expRdata: 32'h55AA_55AA, expStall: 5, expErr: 1'b1};
        vecs[7] = '{ifAdr: 32'h0C, dmAdr: 32'h10, dmWdata: 32'h0, dmRead: 1'b1, dmWrite: 1'b0, dLat: 0, fLat: 0,
                    expInst: 32'h3C1F_00FF, expRdata: 32'hDEAD_BEEF, expStall: 3, expErr: 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst_mem_req", 32'(bus.mem_req), 32'h0);
        checkVal("rst_pipe_stall", 32'(bus.pipe_stall), 32'h1);
        checkVal("rst_if_inst", bus.if_inst, 32'h0);
        checkVal("rst_dm_rdata", bus.dm_rdata, 32'h0);
        checkVal("rst_stall_cnt", bus.stall_cnt, 32'h0);
        checkVal("rst_timeout_err", 32'(bus.timeout_err), 32'h0);

        $display("[TB] boot fetch after reset release");
        bootVec = '{ifAdr: 32'h00, dmAdr: 32'h0, dmWdata: 32'h0, dmRead: 1'b0, dmWrite: 1'b0, dLat: 0, fLat: 0,
                    expInst: 32'h8C01_0004, expRdata: 32'h0, expStall: 2, expErr: 1'b0};
        applyStimulus(bootVec);
        rst = 1'b1;
        tick();
        checkVal("boot_mem_req", 32'(bus.mem_req), 32'h1);
        checkVal("boot_mem_adr", bus.mem_adr, 32'h0);
        runUntilRelease("boot");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            tick();
            runUntilRelease($sformatf("vec%0d", i));
        end

        $display("[TB] reset asserted during a data transaction");
        bus.if_adr  = 32'h04;
        bus.dm_adr  = 32'h30;
        bus.dm_read = 1'b1;
        expTxnQ.push_back('{adr: 32'h30, we: 1'b0, wdata: 32'h0, lat: 10});
        tick();
        tick();
        tick();
        checkVal("pre_reset_mem_req", 32'(bus.mem_req), 32'h1);
        rst         = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        checkVal("midrst_mem_req", 32'(bus.mem_req), 32'h0);
        checkVal("midrst_stall_cnt", bus.stall_cnt, 32'h0);
        checkVal("midrst_pipe_stall", 32'(bus.pipe_stall), 32'h1);
        checkVal("midrst_timeout_err", 32'(bus.timeout_err), 32'h0);
        checkVal("midrst_if_inst", bus.if_inst, 32'h0);
        checkVal("midrst_dm_rdata", bus.dm_rdata, 32'h0);
        expTxnQ.delete();
        expRelQ.delete();
        reqCycles   = 0;
        curStalls   = 0;
        totStall    = 0;
        bus.dm_read = 1'b0;
        rst         = 1'b1;
        expTxnQ.push_back('{adr: 32'h04, we: 1'b0, wdata: 32'h0, lat: 0});
        expRelQ.push_back('{inst: 32'h0022_1820, rdata: 32'h0, stalls: 2, err: 1'b0});
        tick();
        checkVal("restart_mem_req", 32'(bus.mem_req), 32'h1);
        checkVal("restart_mem_adr", bus.mem_adr, 32'h04);
        checkVal("restart_mem_we", 32'(bus.mem_we), 32'h0);
        runUntilRelease("restart");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
